sm4_crypt_core: RTL

//   Iterative SM4 (GB/T 32907) block cipher engine. It consumes the 32 round keys rk00..rk31
//   and the finished flag produced by key_expansion, and encrypts or decrypts one 128-bit block per request.

---
 rtl/sm4_pkg.sv | 49 ++++
 rtl/sm4_crypt_core_if.sv | 23 ++
 rtl/sm4_round_func.sv | 26 ++
 rtl/sm4_crypt_core.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sm4_pkg : shared SM4 tables, FSM encoding and rotate helper  Rev 1.0 |
// +---------------------------------------------------------------------+
package sm4_pkg;

  localparam int NUM_ROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } sm4_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Key-schedule constants; consumed by key_expansion, not by the cipher core.
  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269, 32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249, 32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229, 32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209, 32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_crypt_core_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sm4_crypt_core_if : host block request / result bus         Rev 1.0 |
// +---------------------------------------------------------------------+
interface sm4_crypt_core_if;
  logic         data_valid_in;
  logic         encdec_sel_in;
  logic [127:0] data_in;
  logic         ready_out;
  logic         result_valid_out;
  logic [127:0] result_out;

  modport master (
    output data_valid_in, encdec_sel_in, data_in,
    input  ready_out, result_valid_out, result_out
  );

  modport slave (
    input  data_valid_in, encdec_sel_in, data_in,
    output ready_out, result_valid_out, result_out
  );
endinterface
`default_nettype wire

// File: rtl/sm4_round_func.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sm4_round_func : one SM4 round, x0 ^ L(tau(x1^x2^x3^rk))     Rev 1.0 |
// +---------------------------------------------------------------------+
module sm4_round_func
  import sm4_pkg::*;
(
  input  logic [31:0] i_x0,
  input  logic [31:0] i_x1,
  input  logic [31:0] i_x2,
  input  logic [31:0] i_x3,
  input  logic [31:0] i_rk,
  output logic [31:0] o_x
);

  logic [31:0] w_a;
  logic [31:0] w_b;

  always_comb begin
    w_a = i_x1 ^ i_x2 ^ i_x3 ^ i_rk;
    w_b = {SBOX[w_a[31:24]], SBOX[w_a[23:16]], SBOX[w_a[15:8]], SBOX[w_a[7:0]]};
    o_x = i_x0 ^ w_b ^ rol32(w_b, 2) ^ rol32(w_b, 10) ^ rol32(w_b, 18) ^ rol32(w_b, 24);
  end

endmodule
`default_nettype wire

// File: rtl/sm4_crypt_core.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sm4_crypt_core : iterative SM4 encrypt/decrypt engine        Rev 1.0 |
// | SM4_UNROLL2_EN defined: two rounds per clock                         |
// +---------------------------------------------------------------------+
module sm4_crypt_core
  import sm4_pkg::*;
#(
  parameter int KEY_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sm4_enable_in,
  input  logic        key_exp_finished_in,
  input  logic [31:0] rk00_in, input logic [31:0] rk01_in, input logic [31:0] rk02_in, input logic [31:0] rk03_in,
  input  logic [31:0] rk04_in, input logic [31:0] rk05_in, input logic [31:0] rk06_in, input logic [31:0] rk07_in,
  input  logic [31:0] rk08_in, input logic [31:0] rk09_in, input logic [31:0] rk10_in, input logic [31:0] rk11_in,
  input  logic [31:0] rk12_in, input logic [31:0] rk13_in, input logic [31:0] rk14_in, input logic [31:0] rk15_in,
  input  logic [31:0] rk16_in, input logic [31:0] rk17_in, input logic [31:0] rk18_in, input logic [31:0] rk19_in,
  input  logic [31:0] rk20_in, input logic [31:0] rk21_in, input logic [31:0] rk22_in, input logic [31:0] rk23_in,
  input  logic [31:0] rk24_in, input logic [31:0] rk25_in, input logic [31:0] rk26_in, input logic [31:0] rk27_in,
  input  logic [31:0] rk28_in, input logic [31:0] rk29_in, input logic [31:0] rk30_in, input logic [31:0] rk31_in,
  sm4_crypt_core_if.slave host
);

`ifdef SM4_UNROLL2_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 5;
`endif
  // The last pass is always the all-ones count, so the counter wraps only via DONE.
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  sm4_state_e       r_state;
  sm4_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [31:0]      r_x0, r_x1, r_x2, r_x3;
  logic             r_ready;
  logic             r_valid;
  logic [127:0]     r_result;

  logic [31:0]      w_rk [NUM_ROUNDS];
  logic             w_abort;
  logic             w_accept;
  logic [4:0]       w_idx0;
  logic [31:0]      w_f0;
  logic [127:0]     w_x_next;

  assign w_rk[0]  = rk00_in; assign w_rk[1]  = rk01_in; assign w_rk[2]  = rk02_in; assign w_rk[3]  = rk03_in;
  assign w_rk[4]  = rk04_in; assign w_rk[5]  = rk05_in; assign w_rk[6]  = rk06_in; assign w_rk[7]  = rk07_in;
  assign w_rk[8]  = rk08_in; assign w_rk[9]  = rk09_in; assign w_rk[10] = rk10_in; assign w_rk[11] = rk11_in;
  assign w_rk[12] = rk12_in; assign w_rk[13] = rk13_in; assign w_rk[14] = rk14_in; assign w_rk[15] = rk15_in;
  assign w_rk[16] = rk16_in; assign w_rk[17] = rk17_in; assign w_rk[18] = rk18_in; assign w_rk[19] = rk19_in;
  assign w_rk[20] = rk20_in; assign w_rk[21] = rk21_in; assign w_rk[22] = rk22_in; assign w_rk[23] = rk23_in;
  assign w_rk[24] = rk24_in; assign w_rk[25] = rk25_in; assign w_rk[26] = rk26_in; assign w_rk[27] = rk27_in;
  assign w_rk[28] = rk28_in; assign w_rk[29] = rk29_in; assign w_rk[30] = rk30_in; assign w_rk[31] = rk31_in;

  assign w_abort  = !sm4_enable_in || ((KEY_CHECK != 0) && !key_exp_finished_in);
  assign w_accept = host.data_valid_in && r_ready && !w_abort;

`ifdef SM4_UNROLL2_EN
  logic [4:0]  w_idx1;
  logic [31:0] w_f1;

  assign w_idx0 = r_mode ? {r_cnt, 1'b0} : 5'd31 - {r_cnt, 1'b0};
  assign w_idx1 = r_mode ? {r_cnt, 1'b1} : 5'd30 - {r_cnt, 1'b0};

  sm4_round_func u_round0 (
    .i_x0(r_x0), .i_x1(r_x1), .i_x2(r_x2), .i_x3(r_x3), .i_rk(w_rk[w_idx0]), .o_x(w_f0)
  );
  sm4_round_func u_round1 (
    .i_x0(r_x1), .i_x1(r_x2), .i_x2(r_x3), .i_x3(w_f0), .i_rk(w_rk[w_idx1]), .o_x(w_f1)
  );

  assign w_x_next = {r_x2, r_x3, w_f0, w_f1};
`else
  assign w_idx0 = r_mode ? r_cnt : 5'd31 - r_cnt;

  sm4_round_func u_round0 (
    .i_x0(r_x0), .i_x1(r_x1), .i_x2(r_x2), .i_x3(r_x3), .i_rk(w_rk[w_idx0]), .o_x(w_f0)
  );

  assign w_x_next = {r_x1, r_x2, r_x3, w_f0};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ROUND;
      ROUND:   if (r_cnt == CNT_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_x3     <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      // Ready is raised while DONE retires, so the next accept lands one cycle after the pulse edge.
      r_ready <= (w_next == IDLE) && !w_abort;
      r_valid <= (r_state == DONE) && !w_abort;

      if ((r_state == DONE) && !w_abort) begin
        r_result <= {r_x3, r_x2, r_x1, r_x0};
      end

      if (w_accept || w_abort) begin
        r_cnt <= '0;
      end else if (r_state == ROUND) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_accept) begin
        {r_x0, r_x1, r_x2, r_x3} <= host.data_in;
        r_mode                   <= host.encdec_sel_in;
      end else if ((r_state == ROUND) && !w_abort) begin
        {r_x0, r_x1, r_x2, r_x3} <= w_x_next;
      end
    end
  end

  assign host.ready_out        = r_ready;
  assign host.result_valid_out = r_valid;
  assign host.result_out       = r_result;

endmodule
`default_nettype wire
